periph_bus_arbiter: RTL and testbench

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

---
 rtl/periph_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// Three-master arbiter in front of a single peripheral register bank.
// Each transfer takes three cycles: IDLE (arbitrate and latch the
// command), ACCESS (one-cycle strobe to the bank), DONE (ack to the master).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for requests; picks a winner and latches its command
// ACCESS | strobe to the bank (suppressed for illegal commands)
// DONE   | ack/err pulse to the winner; lock bookkeeping updated
module periph_bus_arbiter #(
  parameter int unsigned LOCK_MAX = 4,
  parameter logic [31:0] WIN_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  m_req,
  input  logic [2:0]  m_lock,
  input  logic [2:0]  m_rd,
  input  logic [2:0]  m_wr,
  input  logic [95:0] m_addr,
  input  logic [95:0] m_wdata,
  output logic [2:0]  m_gnt,
  output logic [2:0]  m_ack,
  output logic        m_err,
  output logic [31:0] m_rdata,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0]  LOCK_LIMIT = 4'(LOCK_MAX);
  localparam logic [31:0] WIN_LAST   = WIN_BASE + 32'd63;

  logic [1:0]  state;
  logic [1:0]  last_gnt;
  logic [1:0]  win;
  logic        win_locked;
  logic        cmd_err;
  logic        lock_valid;
  logic [1:0]  owner;
  logic [3:0]  lock_cnt;

  logic [1:0]  ord0, ord1, ord2;
  logic [1:0]  rr_idx;
  logic        use_lock;
  logic [1:0]  win_idx;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_rd, sel_wr;
  logic        sel_err;

  // Round-robin search order starts just after the last granted master.
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    case (last_gnt)
      2'd0: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd1: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
  end

  // Winner: the lock owner while its budget lasts, otherwise round-robin.
  always_comb begin
    rr_idx = ord2;
    if (m_req[ord0])      rr_idx = ord0;
    else if (m_req[ord1]) rr_idx = ord1;
    use_lock = lock_valid && m_req[owner] && (lock_cnt < LOCK_LIMIT);
    win_idx  = use_lock ? owner : rr_idx;
  end

  // Command mux for the winning master plus legality check.
  always_comb begin
    case (win_idx)
      2'd0:    begin sel_addr = m_addr[31:0];  sel_wdata = m_wdata[31:0];  end
      2'd1:    begin sel_addr = m_addr[63:32]; sel_wdata = m_wdata[63:32]; end
      default: begin sel_addr = m_addr[95:64]; sel_wdata = m_wdata[95:64]; end
    endcase
    sel_rd  = m_rd[win_idx];
    sel_wr  = m_wr[win_idx];
    sel_err = (sel_addr < WIN_BASE) || (sel_addr > WIN_LAST) ||
              (sel_addr[1:0] != 2'b00) || (sel_rd == sel_wr);
  end

  // Transfer sequencing, registered bus/master outputs and lock tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_gnt   <= 2'd2;
      win        <= 2'd0;
      win_locked <= 1'b0;
      cmd_err    <= 1'b0;
      lock_valid <= 1'b0;
      owner      <= 2'd0;
      lock_cnt   <= 4'd0;
      m_gnt      <= 3'b000;
      m_ack      <= 3'b000;
      m_err      <= 1'b0;
      m_rdata    <= 32'd0;
      bus_rd     <= 1'b0;
      bus_wr     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // An absent owner forfeits its lock; round-robin already applies.
          if (lock_valid && !m_req[owner]) begin
            lock_valid <= 1'b0;
            lock_cnt   <= 4'd0;
          end
          if (|m_req) begin
            state      <= S_ACCESS;
            win        <= win_idx;
            win_locked <= use_lock;
            last_gnt   <= win_idx;
            m_gnt      <= 3'b001 << win_idx;
            cmd_err    <= sel_err;
            bus_rd     <= sel_rd & ~sel_err;
            bus_wr     <= sel_wr & ~sel_err;
            bus_addr   <= sel_addr;
            bus_wdata  <= sel_wdata;
          end
        end
        S_ACCESS: begin
          state   <= S_DONE;
          bus_rd  <= 1'b0;
          bus_wr  <= 1'b0;
          m_ack   <= m_gnt;
          m_err   <= cmd_err;
          m_rdata <= bus_rd ? bus_rdata : 32'd0;
        end
        S_DONE: begin
          state   <= S_IDLE;
          m_gnt   <= 3'b000;
          m_ack   <= 3'b000;
          m_err   <= 1'b0;
          m_rdata <= 32'd0;
          if (m_lock[win]) begin
            lock_valid <= 1'b1;
            owner      <= win;
            // Only a grant earned through the lock extends the run; a
            // round-robin re-grant to the same master starts a fresh one.
            if (win_locked && lock_valid && (owner == win))
              lock_cnt <= (lock_cnt == 4'd15) ? 4'd15 : lock_cnt + 4'd1;
            else
              lock_cnt <= 4'd1;
          end else begin
            lock_valid <= 1'b0;
            lock_cnt   <= 4'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: single transfers, round-robin,
// lock with forced rotation, illegal commands and mid-transfer reset.
module tb_periph_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  m_req = '0, m_lock = '0, m_rd = '0, m_wr = '0;
  logic [95:0] m_addr = '0, m_wdata = '0;
  logic [2:0]  m_gnt, m_ack;
  logic        m_err;
  logic [31:0] m_rdata;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] gq[$];
  int         cq[$];

  periph_bus_arbiter #(.LOCK_MAX(4), .WIN_BASE(32'h4000_0000)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_lock(m_lock), .m_rd(m_rd), .m_wr(m_wr),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_req = '0; m_lock = '0; m_rd = '0; m_wr = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Master 0 performs one transfer; drops its request once acked.
  task automatic single_xfer(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdv, input logic exp_err);
    m_req = 3'b001; m_rd = {2'b00, rd}; m_wr = {2'b00, wr};
    m_addr = {64'd0, addr}; m_wdata = {64'd0, wdata}; bus_rdata = rdv;
    step();
    check({tag, "_gnt"},    32'(m_gnt),  32'h1);
    check({tag, "_bus_rd"}, 32'(bus_rd), 32'(rd & ~exp_err));
    check({tag, "_bus_wr"}, 32'(bus_wr), 32'(wr & ~exp_err));
    check({tag, "_ack_early"}, 32'(m_ack), 32'h0);
    if (!exp_err) begin
      check({tag, "_addr"}, bus_addr, addr);
      if (wr) check({tag, "_wdata"}, bus_wdata, wdata);
    end
    step();
    check({tag, "_ack"},    32'(m_ack), 32'h1);
    check({tag, "_err"},    32'(m_err), 32'(exp_err));
    check({tag, "_rdata"},  m_rdata, (rd && !exp_err) ? rdv : 32'h0);
    check({tag, "_strobe_off"}, 32'(bus_rd | bus_wr), 32'h0);
    m_req = '0;
    step();
    check({tag, "_gnt_clr"}, 32'(m_gnt), 32'h0);
    check({tag, "_ack_clr"}, 32'(m_ack), 32'h0);
  endtask

  task automatic run_collect(input int ncyc);
    gq.delete();
    cq.delete();
    for (int c = 1; c <= ncyc; c++) begin
      step();
      check("strobe_excl", 32'(bus_rd & bus_wr), 32'h0);
      if (bus_rd | bus_wr) begin
        gq.push_back(m_gnt);
        cq.push_back(c);
      end
    end
  endtask

  function automatic logic [2:0] gq_at(input int i);
    return (i < gq.size()) ? gq[i] : 3'b000;
  endfunction

  function automatic int cq_at(input int i);
    return (i < cq.size()) ? cq[i] : -1;
  endfunction

  initial begin
    logic [2:0] exp_rr[4];
    logic [2:0] exp_lk[7];
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_lk = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};

    // Reset values
    #2;
    check("rst_gnt",    32'(m_gnt),   32'h0);
    check("rst_ack",    32'(m_ack),   32'h0);
    check("rst_err",    32'(m_err),   32'h0);
    check("rst_rdata",  m_rdata,      32'h0);
    check("rst_strobe", 32'(bus_rd | bus_wr), 32'h0);
    do_reset();

    // Single legal read, then boundary-address read and last-word write
    single_xfer("rd_single", 1'b1, 1'b0, 32'h4000_0010, 32'h0, 32'h0000_00A5, 1'b0);
    single_xfer("rd_base",   1'b1, 1'b0, 32'h4000_0000, 32'h0, 32'h1234_5678, 1'b0);
    single_xfer("wr_last",   1'b0, 1'b1, 32'h4000_003C, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);

    // Illegal commands
    single_xfer("ill_range", 1'b1, 1'b0, 32'h4000_0040, 32'h0, 32'hFFFF_FFFF, 1'b1);
    single_xfer("ill_below", 1'b0, 1'b1, 32'h3FFF_FFFC, 32'h5, 32'hFFFF_FFFF, 1'b1);
    single_xfer("ill_align", 1'b1, 1'b0, 32'h4000_0002, 32'h0, 32'hFFFF_FFFF, 1'b1);
    single_xfer("ill_rdwr",  1'b1, 1'b1, 32'h4000_0004, 32'h0, 32'hFFFF_FFFF, 1'b1);
    single_xfer("ill_none",  1'b0, 1'b0, 32'h4000_0004, 32'h0, 32'hFFFF_FFFF, 1'b1);

    // Round-robin with all three masters writing continuously
    do_reset();
    m_addr  = {32'h4000_0008, 32'h4000_0004, 32'h4000_0000};
    m_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    m_wr = 3'b111; m_rd = 3'b000; m_req = 3'b111;
    run_collect(12);
    check("rr_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_gnt%0d", i), 32'(gq_at(i)), 32'(exp_rr[i]));
      check($sformatf("rr_cyc%0d", i), 32'(cq_at(i)), 32'(1 + 3 * i));
    end

    // Master 1 holds lock: four grants, then forced rotation to 2, then 0
    do_reset();
    m_addr  = {32'h4000_0008, 32'h4000_0004, 32'h4000_0000};
    m_wr = 3'b111; m_rd = 3'b000; m_lock = 3'b010; m_req = 3'b111;
    run_collect(21);
    check("lk_count", 32'(gq.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("lk_gnt%0d", i), 32'(gq_at(i)), 32'(exp_lk[i]));

    // Reset pulsed in the middle of ACCESS
    do_reset();
    m_req = 3'b001; m_wr = 3'b001; m_rd = 3'b000;
    m_addr = {64'd0, 32'h4000_0020}; m_wdata = {64'd0, 32'hCAFE_0001};
    step();
    check("mid_wr_pre", 32'(bus_wr), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_wr",  32'(bus_wr), 32'h0);
    check("mid_gnt", 32'(m_gnt),  32'h0);
    check("mid_ack", 32'(m_ack),  32'h0);
    m_req = '0; m_wr = '0;
    step();
    reset = 1'b0;
    step();
    check("post_ack", 32'(m_ack), 32'h0);
    single_xfer("post_rst", 1'b0, 1'b1, 32'h4000_0020, 32'hCAFE_0002, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
